uart_tx_fifo: RTL and testbench

//   UART transmitter with an input byte FIFO, the output stage paired with the board UART

---
 rtl/uart_tx_fifo.sv | 195 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter (LSB first).
// A producer can burst bytes through a valid/ready handshake while the
// serialiser drains the FIFO with back-to-back, gap-free frames.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (8E1 framing).
module uart_tx_fifo #(
   parameter int DELAY_FRAMES    = 234,
   parameter int FIFO_DEPTH_LOG2 = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [7:0]                 tx_data,
   input  logic                       tx_valid,
   output logic                       tx_ready,
   output logic                       uart_tx,
   output logic                       busy,
   output logic [FIFO_DEPTH_LOG2:0]   fifo_count
);

   localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
   localparam int PTR_W = FIFO_DEPTH_LOG2;
   localparam int CW    = FIFO_DEPTH_LOG2 + 1;
   localparam int CNT_W = $clog2(DELAY_FRAMES);

   localparam logic [CW-1:0]    FULL_COUNT = CW'(DEPTH);
   localparam logic [CNT_W-1:0] LAST_TICK  = CNT_W'(DELAY_FRAMES - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd3;
`endif

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CW-1:0]    count_next;

   logic [2:0]       state;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift_reg;
`ifdef UART_TX_PARITY_EN
   logic             parity_bit;
`endif

   logic             push;
   logic             pop;
   logic             bit_end;
   logic             fifo_empty;

   assign fifo_empty = (fifo_count == '0);
   assign push       = tx_valid & tx_ready;
   assign bit_end    = (baud_cnt == LAST_TICK);
   // A byte leaves the FIFO either from idle or right at the end of a stop bit,
   // which is what makes consecutive frames contiguous.
   assign pop        = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
   assign busy       = (state != IDLE) || !fifo_empty;

   // Next occupancy: a simultaneous push and pop leaves the count unchanged.
   always_comb begin
      count_next = fifo_count;
      if (push && !pop) begin
         count_next = fifo_count + CW'(1);
      end else if (pop && !push) begin
         count_next = fifo_count - CW'(1);
      end
   end

   // FIFO storage; written only on an accepted handshake, never reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= tx_data;
      end
   end

   // FIFO pointers, occupancy and the registered ready flag, which tracks the
   // new count on the same edge so a full FIFO can never accept a byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         tx_ready   <= 1'b1;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         fifo_count <= count_next;
         tx_ready   <= (count_next != FULL_COUNT);
      end
   end

   // Serialiser: each state or data bit lasts DELAY_FRAMES clocks; uart_tx is
   // registered, so it is loaded with the value of the state being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         shift_reg  <= '0;
         uart_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               uart_tx  <= 1'b1;
               baud_cnt <= '0;
               if (pop) begin
                  shift_reg  <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                  parity_bit <= ^mem[rd_ptr];
`endif
                  bit_idx    <= '0;
                  state      <= START;
                  uart_tx    <= 1'b0;
               end
            end
            START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= DATA;
                  uart_tx  <= shift_reg[0];
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud_cnt  <= '0;
                  bit_idx   <= bit_idx + 3'd1;
                  shift_reg <= shift_reg >> 1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state   <= PARITY;
                     uart_tx <= parity_bit;
`else
                     state   <= STOP;
                     uart_tx <= 1'b1;
`endif
                  end else begin
                     uart_tx <= shift_reg[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  state    <= STOP;
                  uart_tx  <= 1'b1;
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
`endif
            STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (pop) begin
                     shift_reg  <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                     parity_bit <= ^mem[rd_ptr];
`endif
                     bit_idx    <= '0;
                     state      <= START;
                     uart_tx    <= 1'b0;
                  end else begin
                     state   <= IDLE;
                     uart_tx <= 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
            default: begin
               state    <= IDLE;
               baud_cnt <= '0;
               uart_tx  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo with DELAY_FRAMES=4 and a
// four-entry FIFO. Define UART_TX_PARITY_EN for both bench and design to
// exercise the 8E1 framing.
module tb_uart_tx_fifo;

   localparam int D    = 4;
   localparam int LOG2 = 2;
`ifdef UART_TX_PARITY_EN
   localparam int FB   = 11;
`else
   localparam int FB   = 10;
`endif

   logic       clk;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       uart_tx;
   logic       busy;
   logic [2:0] fifo_count;

   typedef struct {
      logic       valid;
      logic [7:0] data;
      int         cycles;
      logic       exp_tx;
      logic       exp_busy;
      logic [2:0] exp_count;
      logic       exp_ready;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] exp_q[$];
   int         n_checks;
   int         n_fail;

   uart_tx_fifo #(
      .DELAY_FRAMES    (D),
      .FIFO_DEPTH_LOG2 (LOG2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .uart_tx    (uart_tx),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case a wait never completes.
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation still running at %0t, required to finish", $time);
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      tx_valid = v.valid;
      tx_data  = v.data;
   endtask

   function automatic void addVec(input logic v, input logic [7:0] d, input int n,
                                  input logic tx, input logic bz, input logic [2:0] cnt,
                                  input logic rdy);
      vec_t r;
      r.valid     = v;
      r.data      = d;
      r.cycles    = n;
      r.exp_tx    = tx;
      r.exp_busy  = bz;
      r.exp_count = cnt;
      r.exp_ready = rdy;
      vecs.push_back(r);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pushByte(input logic [7:0] b);
      tx_valid = 1'b1;
      tx_data  = b;
      step();
      tx_valid = 1'b0;
   endtask

   task automatic waitStart(input string name, input int bound);
      logic found;
      found = 1'b0;
      for (int i = 0; i < bound; i++) begin
         step();
         if (uart_tx === 1'b0) begin
            found = 1'b1;
            break;
         end
      end
      checkOutput(name, found, 1);
   endtask

   // Called at the first sample of a start bit; checks every clock of each
   // queued frame, so gaps between frames show up as wrong bit values.
   task automatic checkFrames(input string name);
      logic [10:0] bits;
      logic [7:0]  b;
      logic        ok;
      logic        first;
      int          nb;
      first = 1'b1;
      nb    = exp_q.size();
      for (int k = 0; k < nb; k++) begin
         b       = exp_q.pop_front();
         bits    = '1;
         bits[0] = 1'b0;
         bits[8:1] = b;
`ifdef UART_TX_PARITY_EN
         bits[9] = ^b;
`endif
         for (int i = 0; i < FB; i++) begin
            ok = 1'b1;
            for (int c = 0; c < D; c++) begin
               if (!first) step();
               first = 1'b0;
               if (uart_tx !== bits[i]) ok = 1'b0;
            end
            checkOutput($sformatf("%s_byte%0d_bit%0d", name, k, i), ok, 1);
         end
      end
   endtask

   initial begin
      logic [7:0] pat;
      logic       ok;
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;

      // Reset state
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      step();
      checkOutput("reset_uart_tx", uart_tx, 1);
      checkOutput("reset_ready", tx_ready, 1);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_count", fifo_count, 0);

      // Test 1: 0x55 at idle, checked every clock from a vector table
      pat = 8'h55;
      addVec(1'b1, 8'h55, 1, 1'b1, 1'b1, 3'd1, 1'b1);
      addVec(1'b0, 8'h00, D, 1'b0, 1'b1, 3'd0, 1'b1);
      for (int i = 0; i < 8; i++) addVec(1'b0, 8'h00, D, pat[i], 1'b1, 3'd0, 1'b1);
`ifdef UART_TX_PARITY_EN
      addVec(1'b0, 8'h00, D, ^pat, 1'b1, 3'd0, 1'b1);
`endif
      addVec(1'b0, 8'h00, D, 1'b1, 1'b1, 3'd0, 1'b1);
      addVec(1'b0, 8'h00, 2, 1'b1, 1'b0, 3'd0, 1'b1);
      for (int r = 0; r < vecs.size(); r++) begin
         applyStimulus(vecs[r]);
         for (int c = 0; c < vecs[r].cycles; c++) begin
            step();
            checkOutput($sformatf("t1_row%0d_cyc%0d_tx", r, c), uart_tx, vecs[r].exp_tx);
            checkOutput($sformatf("t1_row%0d_cyc%0d_busy", r, c), busy, vecs[r].exp_busy);
            checkOutput($sformatf("t1_row%0d_cyc%0d_count", r, c), fifo_count, vecs[r].exp_count);
            checkOutput($sformatf("t1_row%0d_cyc%0d_ready", r, c), tx_ready, vecs[r].exp_ready);
         end
      end
      tx_valid = 1'b0;

      // Test 2: three bytes on consecutive clocks give contiguous frames
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h80);
      exp_q.push_back(8'hFF);
      fork
         begin
            tx_valid = 1'b1;
            tx_data  = 8'h01;
            step();
            tx_data  = 8'h80;
            step();
            tx_data  = 8'hFF;
            step();
            tx_valid = 1'b0;
         end
         begin
            waitStart("t2_start", 20);
            checkFrames("t2");
         end
      join
      step();
      checkOutput("t2_busy_end", busy, 0);
      checkOutput("t2_line_idle", uart_tx, 1);

      // Test 3: hold tx_valid until the FIFO fills, then watch ready return
      tx_valid = 1'b1;
      tx_data  = 8'h10;
      step();
      tx_data  = 8'h11;
      step();
      tx_data  = 8'h12;
      step();
      tx_data  = 8'h13;
      step();
      tx_data  = 8'h14;
      step();
      tx_data  = 8'hEE;
      checkOutput("t3_full_count", fifo_count, 4);
      checkOutput("t3_full_ready", tx_ready, 0);
      ok = 1'b1;
      repeat (5) begin
         step();
         if (fifo_count !== 3'd4 || tx_ready !== 1'b0) ok = 1'b0;
      end
      checkOutput("t3_stays_full", ok, 1);
      for (int i = 0; i < 100; i++) begin
         if (fifo_count !== 3'd4) break;
         step();
      end
      tx_valid = 1'b0;
      checkOutput("t3_pop_count", fifo_count, 3);
      checkOutput("t3_pop_ready", tx_ready, 1);
      checkOutput("t3_pop_start", uart_tx, 0);
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h12);
      exp_q.push_back(8'h13);
      exp_q.push_back(8'h14);
      checkFrames("t3");
      step();
      checkOutput("t3_busy_end", busy, 0);
      checkOutput("t3_count_end", fifo_count, 0);

      // Test 4: push coinciding with the stop-bit pop at count 2
      pushByte(8'h3C);
      waitStart("t4_start", 10);
      pushByte(8'hA1);
      pushByte(8'hB2);
      checkOutput("t4_count_two", fifo_count, 2);
      repeat (FB * D - 3) step();
      checkOutput("t4_pre_count", fifo_count, 2);
      checkOutput("t4_pre_stop", uart_tx, 1);
      tx_valid = 1'b1;
      tx_data  = 8'hC3;
      step();
      tx_valid = 1'b0;
      checkOutput("t4_same_edge_count", fifo_count, 2);
      checkOutput("t4_same_edge_ready", tx_ready, 1);
      exp_q.push_back(8'hA1);
      exp_q.push_back(8'hB2);
      exp_q.push_back(8'hC3);
      checkFrames("t4");
      step();
      checkOutput("t4_busy_end", busy, 0);

      // Test 5: asynchronous reset in the middle of a data bit
      pushByte(8'hA3);
      waitStart("t5_start", 10);
      pushByte(8'h5A);
      pushByte(8'h6B);
      repeat (11) step();
      checkOutput("t5_mid_data_low", uart_tx, 0);
      checkOutput("t5_queued", fifo_count, 2);
      #2 rst = 1'b1;
      #1;
      checkOutput("t5_rst_line", uart_tx, 1);
      checkOutput("t5_rst_count", fifo_count, 0);
      checkOutput("t5_rst_ready", tx_ready, 1);
      checkOutput("t5_rst_busy", busy, 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      ok = 1'b1;
      repeat (60) begin
         step();
         if (uart_tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
      end
      checkOutput("t5_no_residual", ok, 1);
      checkOutput("t5_count_after", fifo_count, 0);

`ifdef UART_TX_PARITY_EN
      // Test 6: 0x07 carries an odd number of ones, so the parity bit is 1
      pushByte(8'h07);
      waitStart("t6_start", 10);
      exp_q.push_back(8'h07);
      checkFrames("t6");
      step();
      checkOutput("t6_busy_end", busy, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
